// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, stability-counter debounce, edge strobes and hold-repeat strobes.
// Hold-repeat logic is built only when DEBOUNCE_REPEAT_EN is defined; otherwise repeat_pulse is 0.
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int COUNT_MAX     = 250_000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_level
);
  localparam int CW = COUNT_MAX > 1 ? $clog2(COUNT_MAX) : 1;
  logic [N_CH-1:0] level_q, level_d, rise_q, fall_q, rep_q, rep_d, rise_d, fall_d;
  logic            any_q;
  assign rise_d = level_d & ~level_q;
  assign fall_d = ~level_d & level_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      rep_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rep_q   <= rep_d;
      any_q   <= |level_d;
    end
  end
  assign level        = level_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign repeat_pulse = rep_q;
  assign any_level    = any_q;
  genvar c;
  for (c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   s, diff, term;
    assign s    = sync_q[SYNC_STAGES-1];
    assign diff = s != level_q[c];
    assign term = cnt_q == CW'(COUNT_MAX - 1);
    // Any agreement with the current level, or acceptance, restarts the window.
    assign cnt_d      = (diff && !term) ? cnt_q + CW'(1) : '0;
    assign level_d[c] = (diff && term) ? s : level_q[c];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[c]};
        cnt_q  <= cnt_d;
      end
    end
`ifdef DEBOUNCE_REPEAT_EN
    localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          dly_q, dly_d, held, hit;
    assign held     = level_q[c] & level_d[c];
    assign hold_inc = hold_q + HW'(1);
    // hold_q counts cycles since the last strobe; dly_q marks the initial delay phase.
    assign hit      = held && hold_inc == (dly_q ? HW'(REPEAT_DELAY) : HW'(REPEAT_PERIOD));
    assign hold_d   = (held && !hit) ? hold_inc : '0;
    assign dly_d    = level_d[c] & (rise_d[c] | (dly_q & ~hit));
    assign rep_d[c] = rise_d[c] | hit;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_q <= '0;
        dly_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        dly_q  <= dly_d;
      end
    end
`endif
  end
`ifndef DEBOUNCE_REPEAT_EN
  assign rep_d = '0;
`endif
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: random and directed stimulus against a sample-window reference model.
module tb_debounce_bank;
  localparam int N = 2, CM = 4, SS = 2, RD = 20, RP = 8, L = SS + CM;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] in_r = '0, level, rise, fall, rep;
  logic any;
  debounce_bank #(.N_CH(N), .COUNT_MAX(CM), .SYNC_STAGES(SS), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .in(in_r), .level(level), .rise(rise), .fall(fall),
    .repeat_pulse(rep), .any_level(any)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [N-1:0] hq[$];
  logic [N-1:0] lvl_m, rise_m, fall_m, rep_m;
  int ecnt, rat[N];
  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < L; i++) hq.push_back('0);
    lvl_m = '0; rise_m = '0; fall_m = '0; rep_m = '0;
    for (int c = 0; c < N; c++) rat[c] = 0;
  endtask
  // Level flips once the last CM synchronised samples all disagree with it.
  task automatic model_edge(input logic [N-1:0] smp);
    logic [N-1:0] nl, h;
    logic flip;
    int d;
    ecnt++;
    hq.push_front(smp);
    void'(hq.pop_back());
    for (int c = 0; c < N; c++) begin
      flip = 1'b1;
      for (int j = 0; j < CM; j++) begin
        h = hq[SS + j];
        if (h[c] == lvl_m[c]) flip = 1'b0;
      end
      nl[c] = flip ? ~lvl_m[c] : lvl_m[c];
      rise_m[c] = nl[c] & ~lvl_m[c];
      fall_m[c] = ~nl[c] & lvl_m[c];
      rep_m[c] = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      if (rise_m[c]) begin
        rep_m[c] = 1'b1;
        rat[c] = ecnt;
      end else if (nl[c] && lvl_m[c]) begin
        d = ecnt - rat[c];
        rep_m[c] = d >= RD && (d - RD) % RP == 0;
      end
`endif
    end
    lvl_m = nl;
  endtask
  task automatic step();
    logic [N-1:0] smp;
    @(posedge clk);
    smp = in_r;
    if (rst) model_edge(smp);
    #1;
    check("level", level, lvl_m);
    check("rise", rise, rise_m);
    check("fall", fall, fall_m);
    check("repeat", rep, rep_m);
    check("any", any, |lvl_m);
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check("rst_async", {level, rise, fall, rep, any}, 0);
    model_reset();
    @(posedge clk);
    #1 check("rst_hold", {level, rise, fall, rep, any}, 0);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask
  int cnt;
  initial begin
    model_reset();
    ecnt = 0;
    #12 check("reset_state", {level, rise, fall, rep, any}, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    steps(3);
    in_r = 2'b01;
    steps(5);
    check("press_early", level[0], 1'b0);
    step();
    check("press_level", level[0], 1'b1);
    check("press_rise", rise[0], 1'b1);
    check("press_any", any, 1'b1);
    step();
    check("press_rise_once", rise[0], 1'b0);
    in_r = 2'b00;
    steps(5);
    check("release_early", level[0], 1'b1);
    step();
    check("release_fall", {level[0], fall[0], rep[0]}, 3'b010);
    steps(4);
    in_r = 2'b01;
    steps(3);
    in_r = 2'b00;
    steps(8);
    check("glitch_level", level[0], 1'b0);
    in_r = 2'b01;
    steps(5);
    check("glitch_wait", level[0], 1'b0);
    step();
    check("glitch_accept", level[0], 1'b1);
    in_r = 2'b00;
    steps(8);
    in_r = 2'b01;
    steps(2);
    in_r = 2'b11;
    steps(4);
    check("indep_ch0", level, 2'b01);
    steps(2);
    check("indep_ch1", level, 2'b11);
    in_r = 2'b00;
    steps(8);
    in_r = 2'b11;
    steps(6);
    check("simul_rise", rise, 2'b11);
    in_r = 2'b00;
    steps(8);
    in_r = 2'b01;
    cnt = 0;
    while (!level[0] && cnt < 10) begin
      step();
      cnt++;
    end
    check("repeat_press_seen", level[0], 1'b1);
    cnt = rep[0];
    for (int i = 0; i < 50; i++) begin
      step();
      cnt += rep[0];
    end
`ifdef DEBOUNCE_REPEAT_EN
    check("repeat_count", cnt, 5);
`else
    check("repeat_count", cnt, 0);
`endif
    in_r = 2'b00;
    steps(8);
    check("repeat_release", rep[0], 1'b0);
    in_r = 2'b10;
    steps(6);
    check("pre_rst_level1", level, 2'b10);
    in_r = 2'b11;
    steps(4);
    do_reset();
    steps(5);
    check("post_rst_wait", level, 2'b00);
    step();
    check("post_rst_level", {level, rise}, 4'b1111);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) in_r[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(299) == 0) do_reset();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
